arb4_rr: RTL and testbench

- Round-robin arbiter for four requesters.
- Produces the registered one-hot select lines that drive the 4-to-2 encoder stage: gnt1..gnt4 wire directly to encoder inputs x1..x4.
- Guarantees the encoder only ever sees a one-hot or all-zero input.
- The encoder gives 00 for both "gnt1" and "no grant", so gnt_vld tells these two cases apart downstream.

---
 rtl/arb_pkg.sv | 34 +++
 rtl/rr_pick4.sv | 20 ++
 rtl/arb4_rr.sv | 125 ++++++++++++
 tb/tb_arb4_rr.sv | 127 ++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the four-channel round-robin arbiter: channel count,
// FSM encodings and the rotating priority search.
package arb_pkg;

  localparam int NCH = 4;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Walks from last+1 upward with wrap; channels set in excl are never picked.
  function automatic pick_t rr_pick(input logic [NCH-1:0] req,
                                    input logic [1:0]     last,
                                    input logic [NCH-1:0] excl);
    pick_t          p;
    logic [NCH-1:0] cand;
    logic [1:0]     k;
    p    = '0;
    cand = req & ~excl;
    for (int i = 1; i <= NCH; i++) begin
      k = last + 2'(i);
      if (!p.found && cand[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority pick over four requests, with an exclusion mask.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NCH-1:0] req_i,
  input  logic [1:0]     last_i,
  input  logic [NCH-1:0] excl_i,
  output logic [1:0]     idx_o,
  output logic           found_o
);

  pick_t pick;

  always_comb begin
    pick    = rr_pick(req_i, last_i, excl_i);
    idx_o   = pick.idx;
    found_o = pick.found;
  end

endmodule

// File: rtl/arb4_rr.sv
// Round-robin arbiter for four requesters with a bounded hold time; grants are
// registered one-hot (or all-zero) and feed the 4-to-2 encoder directly.
module arb4_rr
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  output logic           gnt1,
  output logic           gnt2,
  output logic           gnt3,
  output logic           gnt4,
  output logic           gnt_vld,
  output logic [1:0]     last
);

  localparam int CW_RAW = $clog2(MAX_HOLD + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);

  logic [0:0]     state_q, state_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic           vld_q, vld_d;
  logic [1:0]     last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [NCH-1:0] req_c;
  logic [NCH-1:0] cur_oh;
  logic [1:0]     pick_idx, pickx_idx;
  logic           pick_found, pickx_found;
  logic           win_req, others, can_hold;

  // Anything other than a solid 1 (X/Z in simulation) counts as no request.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      req_c[i] = (req[i] === 1'b1);
    end
  end

  assign cur_oh = 4'b0001 << last_q;

  rr_pick4 u_pick (
    .req_i   (req_c),
    .last_i  (last_q),
    .excl_i  ({NCH{1'b0}}),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  rr_pick4 u_pick_excl (
    .req_i   (req_c),
    .last_i  (last_q),
    .excl_i  (cur_oh),
    .idx_o   (pickx_idx),
    .found_o (pickx_found)
  );

  assign win_req  = |(req_c & cur_oh);
  assign others   = |(req_c & ~cur_oh);
  assign can_hold = (MAX_HOLD == 0) || (cnt_q < MAX_C) || !others;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick_idx;
          last_d  = pick_idx;
          cnt_d   = CW'(1);
        end
      end
      default: begin
        if (win_req && can_hold) begin
          if ((MAX_HOLD != 0) && (cnt_q < MAX_C)) begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (win_req && pickx_found) begin
          // Hold budget spent with someone waiting: hand over, skipping ourselves.
          gnt_d  = 4'b0001 << pickx_idx;
          last_d = pickx_idx;
          cnt_d  = CW'(1);
        end else if (pick_found) begin
          gnt_d  = 4'b0001 << pick_idx;
          last_d = pick_idx;
          cnt_d  = CW'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
    vld_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt1    = gnt_q[0];
  assign gnt2    = gnt_q[1];
  assign gnt3    = gnt_q[2];
  assign gnt4    = gnt_q[3];
  assign gnt_vld = vld_q;
  assign last    = last_q;

endmodule

// File: tb/tb_arb4_rr.sv
// Directed bench for arb4_rr: one instance at the default hold limit (8) and one at 2.
module tb_arb4_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic       a_g1, a_g2, a_g3, a_g4, a_vld;
  logic [1:0] a_last;
  logic       b_g1, b_g2, b_g3, b_g4, b_vld;
  logic [1:0] b_last;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  arb4_rr dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt1(a_g1), .gnt2(a_g2), .gnt3(a_g3), .gnt4(a_g4),
    .gnt_vld(a_vld), .last(a_last)
  );

  arb4_rr #(.MAX_HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .req(req),
    .gnt1(b_g1), .gnt2(b_g2), .gnt3(b_g3), .gnt4(b_g4),
    .gnt_vld(b_vld), .last(b_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected grant vectors are {gnt4,gnt3,gnt2,gnt1}; vld is derived from them.
  task automatic expect_both(input string tag,
                             input logic [3:0] ga, input logic [1:0] la,
                             input logic [3:0] gb, input logic [1:0] lb);
    logic [3:0] oa, ob;
    oa = {a_g4, a_g3, a_g2, a_g1};
    ob = {b_g4, b_g3, b_g2, b_g1};
    chk({tag, " a.gnt"},  32'(oa),      32'(ga));
    chk({tag, " a.vld"},  32'(a_vld),   32'(ga != 4'b0));
    chk({tag, " a.last"}, 32'(a_last),  32'(la));
    chk({tag, " b.gnt"},  32'(ob),      32'(gb));
    chk({tag, " b.vld"},  32'(b_vld),   32'(gb != 4'b0));
    chk({tag, " b.last"}, 32'(b_last),  32'(lb));
    chk({tag, " a.onehot"}, 32'($countones(oa) <= 1), 32'd1);
    chk({tag, " b.onehot"}, 32'($countones(ob) <= 1), 32'd1);
  endtask

  logic [3:0] rr_a [9];
  logic [3:0] rr_b [9];
  logic [1:0] rl_a [9];
  logic [1:0] rl_b [9];

  initial begin
    rr_a = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    rl_a = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    rr_b = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    rl_b = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    rst = 1'b1;
    req = 4'b1111;
    step();
    step();
    expect_both("reset", 4'b0000, 2'd3, 4'b0000, 2'd3);

    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      expect_both($sformatf("rr%0d", i), rr_a[i], rl_a[i], rr_b[i], rl_b[i]);
    end

    rst = 1'b1;
    step();
    expect_both("rst2", 4'b0000, 2'd3, 4'b0000, 2'd3);
    rst = 1'b0;

    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_both($sformatf("single%0d", i), 4'b0100, 2'd2, 4'b0100, 2'd2);
    end
    req = 4'b0000;
    step();
    expect_both("single_drop", 4'b0000, 2'd2, 4'b0000, 2'd2);

    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step();
      expect_both($sformatf("lone%0d", i), 4'b0010, 2'd1, 4'b0010, 2'd1);
    end

    req = 4'b0000;
    step();
    expect_both("idle", 4'b0000, 2'd1, 4'b0000, 2'd1);
    req = 4'b0001;
    step();
    expect_both("hand_a", 4'b0001, 2'd0, 4'b0001, 2'd0);
    req = 4'b1000;
    step();
    expect_both("hand_b", 4'b1000, 2'd3, 4'b1000, 2'd3);

    req = 4'b0100;
    step();
    expect_both("hand_c", 4'b0100, 2'd2, 4'b0100, 2'd2);
    rst = 1'b1;
    step();
    expect_both("midrst", 4'b0000, 2'd3, 4'b0000, 2'd3);
    rst = 1'b0;
    step();
    expect_both("post_rst", 4'b0100, 2'd2, 4'b0100, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
